alu_arbiter_ctrl: RTL and testbench

ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

---
 rtl/alu_arbiter_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: two-requester round-robin front end for a shared
// combinational ALU. One operation is in flight at a time. It is granted in
// IDLE, driven to the ALU in EXEC, and held as a response in RESP until the
// consumer takes it.
module alu_arbiter_ctrl #(
  parameter int W       = 4,
  parameter int NUM_OPS = 10
) (
  input  logic         clk,
  input  logic         rst,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_op,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_op,
  // shared ALU
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  // response
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  // Five bits so that NUM_OPS = 16 ("every opcode legal") still fits.
  localparam logic [4:0] NUM_OPS_L = 5'(NUM_OPS);

  state_e       state_q,       state_d;
  logic         last_grant_q,  last_grant_d;
  logic [W-1:0] op_a_q,        op_a_d;
  logic [W-1:0] op_b_q,        op_b_d;
  logic [3:0]   op_code_q,     op_code_d;
  logic         op_id_q,       op_id_d;
  logic         rsp_id_q,      rsp_id_d;
  logic [W-1:0] rsp_result_q,  rsp_result_d;
  logic [3:0]   rsp_flags_q,   rsp_flags_d;
  logic         rsp_err_q,     rsp_err_d;
  logic [7:0]   op_count_q,    op_count_d;

  logic any_valid;
  logic grant_id;
  logic grant_fire;
  logic op_illegal;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    grant_fire = (state_q == ST_IDLE) && any_valid && !rst;
    req0_ready = grant_fire && !grant_id;
    req1_ready = grant_fire &&  grant_id;
    op_illegal = {1'b0, op_code_q} >= NUM_OPS_L;
  end

  // Next-state logic and ALU drive for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // through this block leaves one unassigned and infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d      = ST_EXEC;
          last_grant_d = grant_id;
          op_id_d      = grant_id;
          op_a_d       = grant_id ? req1_a  : req0_a;
          op_b_d       = grant_id ? req1_b  : req0_b;
          op_code_d    = grant_id ? req1_op : req0_op;
        end
      end
      ST_EXEC: begin
        alu_a    = op_a_q;
        alu_b    = op_b_q;
        alu_op   = op_code_q;
        rsp_id_d = op_id_q;
        if (op_illegal) begin
          rsp_result_d = '0;
          rsp_flags_d  = '0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_n, alu_z, alu_c, alu_v};
          rsp_err_d    = 1'b0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d    = ST_IDLE;
          op_count_d = op_count_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, whatever the block order.
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  // Latched operation; only read in EXEC, which is always preceded by a load.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers are left without reset; the FSM
    // guarantees they are written before they are ever observed.
    op_a_q    <= op_a_d;
    op_b_q    <= op_b_d;
    op_code_q <= op_code_d;
    op_id_q   <= op_id_d;
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: a transaction-level model (one operation in
// flight, counted in cycles since acceptance) is compared against the DUT on
// every cycle, alongside directed scenarios with hand-computed values.
module tb_alu_arbiter_ctrl;

  localparam int W       = 4;
  localparam int NUM_OPS = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_op;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [7:0]   op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.W(W), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z),
    .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  // Environment ALU: returns {result, N, Z, C, V}. Illegal opcodes produce
  // deliberately non-zero junk so the DUT's zeroing is observable.
  function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
    logic [W-1:0] r;
    logic [W:0]   wide;
    logic         n, c, v;
    r = '0; wide = '0; n = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      4'd1: begin
        r = a - b; c = (a < b); n = r[W-1];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd2: begin r = a & b; n = r[W-1]; end
      4'd3: begin r = a | b; n = r[W-1]; end
      4'd4: begin r = a ^ b; n = r[W-1]; end
      4'd5: begin r = a << 1; c = a[W-1]; n = r[W-1]; end
      4'd6: begin r = a >> 1; c = a[0]; end
      4'd7: begin r = ~a; n = r[W-1]; end
      4'd8: begin r = b; end
      4'd9: begin wide = {1'b0, a} + (W+1)'(1); r = wide[W-1:0]; c = wide[W]; end
      default: begin r = a ^ ~b; n = 1'b1; c = 1'b1; v = 1'b1; end
    endcase
    return {r, n, (r == '0), c, v};
  endfunction

  always_comb {alu_result, alu_n, alu_z, alu_c, alu_v} = alu_fn(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         id;
  } txn_t;

  bit           m_busy;      // an operation has been accepted and not yet consumed
  int           m_age;       // cycles since acceptance (0 = on the ALU)
  txn_t         m_txn;
  int           m_last;      // requester granted most recently
  int           m_count;
  logic         m_rsp_id;
  logic [W-1:0] m_rsp_res;
  logic [3:0]   m_rsp_flags;
  logic         m_rsp_err;

  function automatic int m_pick();
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    return req0_valid ? 0 : 1;
  endfunction

  task automatic m_update();
    logic [W+3:0] out;
    if (rst) begin
      m_busy = 0; m_age = 0; m_last = 1; m_count = 0;
      m_rsp_id = 0; m_rsp_res = '0; m_rsp_flags = '0; m_rsp_err = 0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        int g = m_pick();
        m_txn.id = g[0];
        m_txn.a  = g == 0 ? req0_a  : req1_a;
        m_txn.b  = g == 0 ? req0_b  : req1_b;
        m_txn.op = g == 0 ? req0_op : req1_op;
        m_last = g; m_busy = 1; m_age = 0;
      end
    end else if (m_age == 0) begin
      out = alu_fn(m_txn.a, m_txn.b, m_txn.op);
      m_rsp_id = m_txn.id;
      if (int'(m_txn.op) >= NUM_OPS) begin
        m_rsp_res = '0; m_rsp_flags = '0; m_rsp_err = 1;
      end else begin
        m_rsp_res = out[W+3:4]; m_rsp_flags = out[3:0]; m_rsp_err = 0;
      end
      m_age = 1;
    end else if (rsp_ready) begin
      m_count = (m_count + 1) % 256;
      m_busy = 0;
    end
  endtask

  task automatic m_compare();
    bit on_alu = m_busy && (m_age == 0);
    bit has_rsp = m_busy && (m_age >= 1);
    bit can_grant = !rst && !m_busy && (req0_valid || req1_valid);
    int g = m_pick();
    check("req0_ready", 32'(req0_ready), 32'(can_grant && g == 0));
    check("req1_ready", 32'(req1_ready), 32'(can_grant && g == 1));
    check("alu_a",  32'(alu_a),  on_alu ? 32'(m_txn.a)  : 32'd0);
    check("alu_b",  32'(alu_b),  on_alu ? 32'(m_txn.b)  : 32'd0);
    check("alu_op", 32'(alu_op), on_alu ? 32'(m_txn.op) : 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'(has_rsp));
    check("op_count", 32'(op_count), 32'(m_count));
    if (has_rsp) begin
      check("rsp_id",     32'(rsp_id),     32'(m_rsp_id));
      check("rsp_result", 32'(rsp_result), 32'(m_rsp_res));
      check("rsp_flags",  32'(rsp_flags),  32'(m_rsp_flags));
      check("rsp_err",    32'(rsp_err),    32'(m_rsp_err));
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising one.
  task automatic step();
    @(negedge clk);
    m_compare();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] op);
    if (r == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  int grants[$];
  int ids[$];

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    @(posedge clk); m_update(); #1;

    // Reset values, and readys held low while reset is asserted.
    set_req(0, 1, 4'd1, 4'd1, 4'd0);
    set_req(1, 1, 4'd1, 4'd1, 4'd0);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_rsp_payload", {rsp_id, rsp_result, rsp_flags, rsp_err}, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("rst_readys", {req0_ready, req1_ready}, 0);
    step();
    rst = 1'b0;
    set_req(1, 0, '0, '0, '0);

    // Single op: 3 + 5 from requester 0.
    set_req(0, 1, 4'd3, 4'd5, 4'd0); rsp_ready = 1'b1; #1;
    check("single_ready", {req0_ready, req1_ready}, 32'b10);
    step();
    set_req(0, 0, '0, '0, '0); #1;
    check("single_alu", {alu_a, alu_b, alu_op, rsp_valid}, {4'd3, 4'd5, 4'd0, 1'b0});
    step(); #1;
    check("single_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err},
          {1'b1, 1'b0, 4'd8, 4'b0000, 1'b0});
    step(); #1;
    check("single_count", {rsp_valid, op_count}, {1'b0, 8'd1});

    // Tie after reset: grants alternate starting with requester 0.
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1, 4'd2, 4'd7, 4'd3);
    set_req(1, 1, 4'd6, 4'd1, 4'd1);
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid)  ids.push_back(int'(rsp_id));
      step();
    end
    check("tie_grant_count", grants.size(), 4);
    check("tie_id_count", ids.size(), 4);
    for (int i = 0; i < 4 && i < grants.size() && i < ids.size(); i++) begin
      check("tie_grant_order", grants[i], i % 2);
      check("tie_id_order", ids[i], i % 2);
    end

    // Backpressure: five cycles in RESP with requester 1 waiting.
    set_req(0, 1, 4'd9, 4'd6, 4'd4); set_req(1, 0, '0, '0, '0); rsp_ready = 1'b0; #1;
    check("bp_accept", {req0_ready, req1_ready}, 32'b10);
    step();
    set_req(0, 0, '0, '0, '0); set_req(1, 1, 4'd5, 4'd5, 4'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, req0_ready, req1_ready},
            {1'b1, 1'b0, 4'hF, 4'b1000, 1'b0, 1'b0, 1'b0});
      check("bp_count_held", 32'(op_count), 4);
      step();
    end
    rsp_ready = 1'b1; step(); #1;
    check("bp_release", {rsp_valid, op_count, req1_ready}, {1'b0, 8'd5, 1'b1});

    // Illegal opcode from requester 1.
    set_req(1, 1, 4'd7, 4'd3, 4'd12); rsp_ready = 1'b0;
    step();
    set_req(1, 0, '0, '0, '0);
    step(); #1;
    check("illegal_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err},
          {1'b1, 1'b1, 4'd0, 4'b0000, 1'b1});
    rsp_ready = 1'b1; step();

    // Reset while a response is pending; requester 0 won last.
    set_req(0, 1, 4'd2, 4'd2, 4'd1); rsp_ready = 1'b0;
    step();
    set_req(0, 0, '0, '0, '0);
    step(); #1;
    check("rr_pending", {rsp_valid, rsp_result, rsp_flags}, {1'b1, 4'd0, 4'b0100});
    rst = 1'b1; step(); rst = 1'b0; #1;
    check("rr_cleared", {rsp_valid, op_count}, 0);
    set_req(0, 1, 4'd1, 4'd2, 4'd0); set_req(1, 1, 4'd3, 4'd4, 4'd0); #1;
    check("rr_tie_first", {req0_ready, req1_ready}, 32'b10);

    // Randomized traffic, occasional reset, every opcode including illegal ones.
    for (int i = 0; i < 600; i++) begin
      set_req(0, ($urandom_range(0, 2) != 0), W'($urandom), W'($urandom), 4'($urandom_range(0, 15)));
      set_req(1, ($urandom_range(0, 2) != 0), W'($urandom), W'($urandom), 4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    // Wrap: 256 back-to-back ops from requester 0 return op_count to 0.
    rst = 1'b1; step(); rst = 1'b0;
    set_req(1, 0, '0, '0, '0); rsp_ready = 1'b1;
    for (int i = 0; i < 768; i++) begin
      set_req(0, 1, W'($urandom), W'($urandom), 4'($urandom_range(0, 9)));
      step();
      if (i == 764) check("wrap_255", 32'(op_count), 255);
    end
    check("wrap_0", 32'(op_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
